// File: rtl/y_adder_pkg.sv
// Shared definitions for the y_adder datapath adder.
//   ADDER_WIDTH : default operand/sum width
//   word_t      : one ADDER_WIDTH-bit datapath word
package y_adder_pkg;

  localparam int ADDER_WIDTH = 32;

  typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : y_adder_pkg

// File: rtl/y_adder_yadder1.sv
// yAdder1: single-bit full adder built from gate primitives.
// Ports:
//   z    : sum bit,   a ^ b ^ cin
//   cout : carry out, (a & b) | (cin & (a ^ b))
//   a, b : operand bits
//   cin  : carry in
module yAdder1 (
  output logic z,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic axb;
  logic g;
  logic p;

  xor u_x0 (axb, a, b);
  xor u_x1 (z, axb, cin);
  and u_a0 (g, a, b);
  and u_a1 (p, cin, axb);
  or  u_o0 (cout, g, p);

endmodule : yAdder1

// File: rtl/y_adder.sv
// y_adder: parameterised ripple-carry adder, z = a + b + cin, with carry-out.
// The sum/carry path is purely combinational and ignores clk/rst; a registered
// copy of the result plus a two's-complement overflow flag is captured every
// rising clk edge for pipelined consumers.
// Ports:
//   z      : combinational sum, (a + b + cin) mod 2^WIDTH
//   cout   : combinational carry out of the MSB
//   a, b   : operands
//   cin    : carry into the LSB
//   clk    : clock, registers update on rising edge
//   rst    : asynchronous active-high reset, clears registered outputs
//   z_r    : registered z
//   cout_r : registered cout
//   ovf_r  : registered signed overflow
module y_adder
  import y_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  output logic [WIDTH-1:0] z,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] z_r,
  output logic             cout_r,
  output logic             ovf_r
);

  // c[i] is the carry into bit i; c[0] is cin and c[WIDTH] the carry out.
  wire [WIDTH:0] c;
  logic          ovf_p0;

  logic [WIDTH-1:0] z_p1;
  logic             cout_p1;
  logic             ovf_p1;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    yAdder1 u_fa (
      .z    (z[i]),
      .cout (c[i+1]),
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i])
    );
  end

  assign cout = c[WIDTH];

  // Overflow when the carry into the sign bit differs from the carry out of
  // it. For WIDTH == 1 the carry into the sign bit is cin itself.
  assign ovf_p0 = c[WIDTH] ^ c[WIDTH-1];

  // ---- stage p0 -> p1: capture register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_p1    <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      z_p1    <= z;
      cout_p1 <= cout;
      ovf_p1  <= ovf_p0;
    end
  end

  assign z_r    = z_p1;
  assign cout_r = cout_p1;
  assign ovf_r  = ovf_p1;

endmodule : y_adder

// File: tb/tb_y_adder.sv
// Self-checking bench for y_adder at the default 32-bit width.
module tb_y_adder;

  localparam int W = 32;

  logic [W-1:0] z, a, b, z_r;
  logic         cout, cin, clk, rst, cout_r, ovf_r;

  int errors = 0;
  int checks = 0;

  y_adder #(.WIDTH(W)) dut (
    .z      (z),
    .cout   (cout),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .clk    (clk),
    .rst    (rst),
    .z_r    (z_r),
    .cout_r (cout_r),
    .ovf_r  (ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] ez;
    logic         ecout;
    logic         eovf;
  } vec_t;

  // Reference: exact integer sum at W+1 bits; overflow by operand/result signs.
  function automatic logic [W:0] ref_sum(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    longint unsigned s;
    s = longint'(x) + longint'(y) + longint'(ci);
    return s[W:0];
  endfunction

  function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic ci);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = sx + sy + longint'(ci);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply between edges, check combinational path, then the captured copy.
  task automatic apply_and_check(string tag, logic [W-1:0] va, logic [W-1:0] vb,
                                 logic vc, logic [W-1:0] ez, logic ec, logic eo);
    @(negedge clk);
    a = va; b = vb; cin = vc;
    #1;
    chk({tag, ".z"}, 64'(z), 64'(ez));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    @(posedge clk);
    #1;
    chk({tag, ".z_r"}, 64'(z_r), 64'(ez));
    chk({tag, ".cout_r"}, 64'(cout_r), 64'(ec));
    chk({tag, ".ovf_r"}, 64'(ovf_r), 64'(eo));
  endtask

  vec_t tbl[6];

  initial begin
    logic [W:0] s;
    logic [W-1:0] ra, rb;
    logic rc;

    tbl[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};

    // Reset state, with operands that would otherwise produce non-zero results.
    rst = 1'b1; a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1;
    #1;
    chk("rst.z_r", 64'(z_r), 64'd0);
    chk("rst.cout_r", 64'(cout_r), 64'd0);
    chk("rst.ovf_r", 64'(ovf_r), 64'd0);
    chk("rst.z_comb", 64'(z), 64'h1);
    @(posedge clk); #1;
    chk("rst_hold.z_r", 64'(z_r), 64'd0);
    chk("rst_hold.ovf_r", 64'(ovf_r), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      apply_and_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                      tbl[i].ez, tbl[i].ecout, tbl[i].eovf);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i == 0) ra[31] = 1'b0;
      if (i == 0) rb = 32'h7FFF_FFFF - ra + 32'd5;
      s = ref_sum(ra, rb, rc);
      apply_and_check($sformatf("rnd%0d", i), ra, rb, rc, s[W-1:0], s[W],
                      ref_ovf(ra, rb, rc));
    end

    // 5 + 3 captured, then reset between edges clears registers at once.
    apply_and_check("five3", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.z_r", 64'(z_r), 64'd0);
    chk("midrst.cout_r", 64'(cout_r), 64'd0);
    chk("midrst.ovf_r", 64'(ovf_r), 64'd0);
    chk("midrst.z", 64'(z), 64'd8);
    @(negedge clk);
    rst = 1'b0;

    // Overflow/carry flags set, then cleared asynchronously.
    apply_and_check("flags", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("flagrst.cout_r", 64'(cout_r), 64'd0);
    chk("flagrst.ovf_r", 64'(ovf_r), 64'd0);
    chk("flagrst.cout", 64'(cout), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("recap.cout_r", 64'(cout_r), 64'd1);
    chk("recap.ovf_r", 64'(ovf_r), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_y_adder

// File: doc/y_adder.md
# y_adder

Parameterised ripple-carry adder, 32 bits by default, that computes z = a + b + cin and the carry-out.
Sum and carry are combinational and valid within the same evaluation step as the operands.
A registered copy of the result, plus a signed-overflow flag, is captured every clock for downstream pipelined consumers.
It is the datapath adder used by the ALU/lab datapath blocks.

## Interface
Parameters:
- WIDTH, 32, operand and sum width; legal values are 1 and above.

Ports:
- clk  input  1  single clock; all registered outputs update on its rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registered outputs.
- z  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out of the MSB.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to the LSB.
- z_r  output  WIDTH  registered z.
- cout_r  output  1  registered cout.
- ovf_r  output  1  registered two's-complement overflow.

Positional port order is fixed: z, cout, a, b, cin, clk, rst, z_r, cout_r, ovf_r. Existing benches connect the first five positionally.

## Operation
- Bit i is a full adder:
  - z[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = cin; cout = c[WIDTH].
- The full result {cout, z} equals a + b + cin exactly, computed at WIDTH+1 bits. There is no saturation.
- Signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0] is cin.
- The combinational outputs z and cout do not depend on clk or rst. They are valid even while rst is asserted.
- Registered outputs:
  - On each rising clk edge with rst low: z_r <= z, cout_r <= cout, ovf_r <= ovf.
- Inputs with X or Z bits may propagate X to z and cout. There is no X-cleanup logic.
- No handshake and no state machine. The block accepts new operands every cycle.

## Timing
- z and cout have zero cycle latency. They must settle within one time unit of an operand change in zero-delay simulation.
- z_r, cout_r and ovf_r have one-cycle latency: they reflect the operands present at the last rising edge.
- Reset values: z_r = 0, cout_r = 0, ovf_r = 0.
- Reset asserts asynchronously and takes effect immediately, without waiting for a clock edge.
- Reset deasserts synchronously to clk from the bench's point of view. The first capture happens at the first rising edge with rst low.
- Reset asserted mid-stream clears the registers at once. The combinational path is unaffected.
- If an operand changes in the same step as a rising edge, the registers capture the settled value from before that edge (standard nonblocking semantics).

## Structure
- Sub-module yAdder1: 1-bit full adder with ports (z, cout, a, b, cin), built from gate primitives.
- The top level instantiates WIDTH copies in a generate loop and chains the carries.
- The shared package holds the default width constant (ADDER_WIDTH = 32) and a typedef for the WIDTH-bit word.
- No other sub-modules.

## Test plan
- a=0x00000000, b=0x00000000, cin=0 -> z=0x00000000, cout=0; after one edge z_r=0, ovf_r=0.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> z=0x00000000, cout=1 (full carry ripple through all bits); ovf_r=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> z=0x80000000, cout=0; after one edge ovf_r=1.
- a=0x80000000, b=0x80000000, cin=1 -> z=0x00000001, cout=1; ovf_r=1.
- 10 or more random triples (a, b, cin) -> z must equal (a+b+cin) mod 2^32, checked one time unit after apply, with cout equal to bit 32 of the 33-bit sum. Any mismatch is reported as FAIL.
- Apply a=5, b=3 and clock once so z_r=8. Then assert rst between edges -> z_r, cout_r and ovf_r are 0 immediately, while z remains 8.
